// File: rtl/if_fetch_queue_pkg.sv
// ---------------------------------------------------------------------------
// if_fetch_queue_pkg
// Shared constants for the fetch-queue slice: default data width, boolean
// and zero literals, and the fetch FSM state encoding.
// ---------------------------------------------------------------------------
package if_fetch_queue_pkg;

   localparam int unsigned XLEN_DEF = 32;

   localparam logic TRUE  = 1'b1;
   localparam logic FALSE = 1'b0;

   localparam logic [XLEN_DEF-1:0] ZERO = '0;

   typedef enum logic [1:0] {
      IF_IDLE  = 2'b00,
      IF_FETCH = 2'b01,
      IF_DRAIN = 2'b11
   } if_state_e;

endpackage

// File: rtl/if_iq_fifo.sv
// ---------------------------------------------------------------------------
// if_iq_fifo
// Synchronous FIFO of {jump, pc, instr} entries feeding the dispatcher.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   i_rdy               global enable; low holds pointers, count and storage
//   i_flush             empties the queue; overrides push and pop
//   i_push              write {i_jump, i_pc, i_instr} at the tail
//   i_pop               retire the head (ignored while empty)
//   o_jump/o_pc/o_instr head entry
//   o_count             occupancy, 0..DEPTH
// ---------------------------------------------------------------------------
module if_iq_fifo
   import if_fetch_queue_pkg::*;
#(
   parameter int unsigned XLEN  = XLEN_DEF,
   parameter int unsigned DEPTH = 4,
   parameter int unsigned IDX_W = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_rdy,
   input  logic             i_flush,
   input  logic             i_push,
   input  logic             i_pop,
   input  logic             i_jump,
   input  logic [XLEN-1:0]  i_pc,
   input  logic [XLEN-1:0]  i_instr,
   output logic             o_jump,
   output logic [XLEN-1:0]  o_pc,
   output logic [XLEN-1:0]  o_instr,
   output logic [IDX_W:0]   o_count
);

   localparam logic [IDX_W-1:0] PTR_ONE = 1;
   localparam logic [IDX_W:0]   CNT_ONE = 1;

   logic [XLEN-1:0]  r_pc    [DEPTH];
   logic [XLEN-1:0]  r_instr [DEPTH];
   logic             r_jump  [DEPTH];
   logic [IDX_W-1:0] r_head;
   logic [IDX_W-1:0] r_tail;
   logic [IDX_W:0]   r_count;
   logic             w_pop;

   assign w_pop = i_pop & (r_count != '0);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
      end else if (i_rdy) begin
         if (i_flush) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
         end else begin
            if (i_push) r_tail <= r_tail + PTR_ONE;
            if (w_pop)  r_head <= r_head + PTR_ONE;
            if (i_push && !w_pop)      r_count <= r_count + CNT_ONE;
            else if (!i_push && w_pop) r_count <= r_count - CNT_ONE;
         end
      end
   end

   // Storage carries no reset; only valid entries are ever observed.
   always_ff @(posedge clk) begin
      if (i_rdy && !i_flush && i_push) begin
         r_pc[r_tail]    <= i_pc;
         r_instr[r_tail] <= i_instr;
         r_jump[r_tail]  <= i_jump;
      end
   end

   assign o_pc    = r_pc[r_head];
   assign o_instr = r_instr[r_head];
   assign o_jump  = r_jump[r_head];
   assign o_count = r_count;

endmodule

// File: rtl/if_fetch_queue.sv
// ---------------------------------------------------------------------------
// if_fetch_queue
// Instruction fetcher with one outstanding i-cache request and an IQ_DEPTH
// entry instruction queue drained by the dispatcher (valid/ready).
// Ports:
//   clk, rst, rdy                 clock, sync active-high reset, global enable
//   ic_req_valid/ic_req_pc        i-cache request (address stable until resp)
//   ic_resp_valid/ic_resp_instr   i-cache response pulse and instruction
//   pred_valid/pred_instr/pred_pc pass-through to the branch predictor
//   pred_jump/pred_next_pc        predictor decision for the current pc
//   dsp_valid/dsp_ready           head handshake to the dispatcher
//   dsp_pc/dsp_instr/dsp_jump     head entry
//   rollback/rollback_pc          ROB flush and restart address
//   iq_count                      queue occupancy
// ---------------------------------------------------------------------------
module if_fetch_queue
   import if_fetch_queue_pkg::*;
#(
   parameter int unsigned XLEN     = XLEN_DEF,
   parameter int unsigned IQ_DEPTH = 4,
   parameter int unsigned IQ_IDX_W = $clog2(IQ_DEPTH)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                rdy,
   output logic                ic_req_valid,
   output logic [XLEN-1:0]     ic_req_pc,
   input  logic                ic_resp_valid,
   input  logic [XLEN-1:0]     ic_resp_instr,
   output logic                pred_valid,
   output logic [XLEN-1:0]     pred_instr,
   output logic [XLEN-1:0]     pred_pc,
   input  logic                pred_jump,
   input  logic [XLEN-1:0]     pred_next_pc,
   output logic                dsp_valid,
   input  logic                dsp_ready,
   output logic [XLEN-1:0]     dsp_pc,
   output logic [XLEN-1:0]     dsp_instr,
   output logic                dsp_jump,
   input  logic                rollback,
   input  logic [XLEN-1:0]     rollback_pc,
   output logic [IQ_IDX_W:0]   iq_count
);

   if_state_e             r_state, w_state;
   logic [XLEN-1:0]       r_pc, w_pc;
   logic [XLEN-1:0]       r_req_pc, w_req_pc;
   logic                  r_req_valid, w_req_valid;
   logic [IQ_IDX_W:0]     w_count;
   logic [IQ_IDX_W+1:0]   w_cnt_next;
   logic                  w_push;
   logic                  w_pop;

   assign dsp_valid  = (w_count != '0);
   assign w_pop      = dsp_valid & dsp_ready;
   assign w_push     = (r_state == IF_FETCH) & ic_resp_valid & ~rollback;
   assign w_cnt_next = {1'b0, w_count} + (IQ_IDX_W+2)'(1) - (IQ_IDX_W+2)'(w_pop);

   assign pred_valid   = ic_resp_valid;
   assign pred_instr   = ic_resp_instr;
   assign pred_pc      = r_pc;
   assign ic_req_valid = r_req_valid;
   assign ic_req_pc    = r_req_pc;
   assign iq_count     = w_count;

   if_iq_fifo #(
      .XLEN  (XLEN),
      .DEPTH (IQ_DEPTH),
      .IDX_W (IQ_IDX_W)
   ) u_iq (
      .clk     (clk),
      .rst     (rst),
      .i_rdy   (rdy),
      .i_flush (rollback),
      .i_push  (w_push),
      .i_pop   (w_pop),
      .i_jump  (pred_jump),
      .i_pc    (r_pc),
      .i_instr (ic_resp_instr),
      .o_jump  (dsp_jump),
      .o_pc    (dsp_pc),
      .o_instr (dsp_instr),
      .o_count (w_count)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= IF_IDLE;
         r_pc        <= XLEN'(ZERO);
         r_req_pc    <= XLEN'(ZERO);
         r_req_valid <= FALSE;
      end else if (rdy) begin
         r_state     <= w_state;
         r_pc        <= w_pc;
         r_req_pc    <= w_req_pc;
         r_req_valid <= w_req_valid;
      end
   end

   always_comb begin
      w_state     = r_state;
      w_pc        = r_pc;
      w_req_pc    = r_req_pc;
      w_req_valid = r_req_valid;
      if (rollback) begin
         // The outstanding request keeps its address; its response is
         // dropped, either now or later from DRAIN.
         w_pc = rollback_pc;
         unique case (r_state)
            IF_FETCH, IF_DRAIN: begin
               if (ic_resp_valid) begin
                  w_req_valid = FALSE;
                  w_state     = IF_IDLE;
               end else begin
                  w_state = IF_DRAIN;
               end
            end
            default: w_state = IF_IDLE;
         endcase
      end else begin
         unique case (r_state)
            IF_IDLE: begin
               if (w_count < (IQ_IDX_W+1)'(IQ_DEPTH)) begin
                  w_req_pc    = r_pc;
                  w_req_valid = TRUE;
                  w_state     = IF_FETCH;
               end
            end
            IF_FETCH: begin
               if (ic_resp_valid) begin
                  w_pc = pred_next_pc;
                  // Issue back-to-back only while a slot stays reserved.
                  if (w_cnt_next < (IQ_IDX_W+2)'(IQ_DEPTH)) begin
                     w_req_pc = pred_next_pc;
                  end else begin
                     w_req_valid = FALSE;
                     w_state     = IF_IDLE;
                  end
               end
            end
            IF_DRAIN: begin
               if (ic_resp_valid) begin
                  w_req_valid = FALSE;
                  w_state     = IF_IDLE;
               end
            end
            default: w_state = IF_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_if_fetch_queue.sv
module tb_if_fetch_queue;
   import if_fetch_queue_pkg::*;

   logic        clk = 1'b0;
   logic        rst, rdy;
   logic        ic_req_valid;
   logic [31:0] ic_req_pc;
   logic        ic_resp_valid;
   logic [31:0] ic_resp_instr;
   logic        pred_valid;
   logic [31:0] pred_instr, pred_pc;
   logic        pred_jump;
   logic [31:0] pred_next_pc;
   logic        dsp_valid, dsp_ready;
   logic [31:0] dsp_pc, dsp_instr;
   logic        dsp_jump;
   logic        rollback;
   logic [31:0] rollback_pc;
   logic [2:0]  iq_count;

   int n_tests = 0;
   int n_fail  = 0;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] instr;
      logic        jump;
   } sb_t;
   sb_t sb[$];
   sb_t mon_e;

   typedef struct {
      logic        resp;
      logic [31:0] ipc;
      logic        jump;
      logic [31:0] npc;
      logic        drdy;
      logic        e_reqv;
      logic [31:0] e_reqpc;
      logic [31:0] e_cnt;
   } vec_t;
   vec_t tbl[16];

   if_fetch_queue #(.XLEN(32), .IQ_DEPTH(4)) dut (
      .clk           (clk),
      .rst           (rst),
      .rdy           (rdy),
      .ic_req_valid  (ic_req_valid),
      .ic_req_pc     (ic_req_pc),
      .ic_resp_valid (ic_resp_valid),
      .ic_resp_instr (ic_resp_instr),
      .pred_valid    (pred_valid),
      .pred_instr    (pred_instr),
      .pred_pc       (pred_pc),
      .pred_jump     (pred_jump),
      .pred_next_pc  (pred_next_pc),
      .dsp_valid     (dsp_valid),
      .dsp_ready     (dsp_ready),
      .dsp_pc        (dsp_pc),
      .dsp_instr     (dsp_instr),
      .dsp_jump      (dsp_jump),
      .rollback      (rollback),
      .rollback_pc   (rollback_pc),
      .iq_count      (iq_count)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] mk_instr(input logic [31:0] pc);
      return pc ^ 32'hA5A5_0013;
   endfunction

   function automatic vec_t mkv(input logic resp, input logic [31:0] ipc, input logic jump,
                                input logic [31:0] npc, input logic drdy, input logic e_reqv,
                                input logic [31:0] e_reqpc, input logic [31:0] e_cnt);
      vec_t v;
      v.resp = resp; v.ipc = ipc; v.jump = jump; v.npc = npc; v.drdy = drdy;
      v.e_reqv = e_reqv; v.e_reqpc = e_reqpc; v.e_cnt = e_cnt;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Drive one cycle of stimulus; acc marks a response the DUT must enqueue.
   task automatic step(input logic rb, input logic [31:0] rbpc, input logic resp,
                       input logic [31:0] ipc, input logic acc, input logic jump,
                       input logic [31:0] npc, input logic drdy);
      sb_t e;
      rollback      = rb;
      rollback_pc   = rbpc;
      ic_resp_valid = resp;
      ic_resp_instr = mk_instr(ipc);
      pred_jump     = jump;
      pred_next_pc  = npc;
      dsp_ready     = drdy;
      if (acc) begin
         e.pc = ipc; e.instr = mk_instr(ipc); e.jump = jump;
         sb.push_back(e);
      end
      tick();
      if (rb) sb.delete();
      rollback      = 1'b0;
      ic_resp_valid = 1'b0;
   endtask

   task automatic st(input string tag, input logic reqv, input logic [31:0] reqpc,
                     input logic [31:0] cnt);
      chk({tag, ".req_valid"}, {31'd0, ic_req_valid}, {31'd0, reqv});
      chk({tag, ".req_pc"}, ic_req_pc, reqpc);
      chk({tag, ".iq_count"}, {29'd0, iq_count}, cnt);
      chk({tag, ".dsp_valid"}, {31'd0, dsp_valid}, {31'd0, cnt != 0});
   endtask

   // Dispatch monitor: each accepted head must match the oldest expected entry.
   initial forever begin
      @(negedge clk);
      if (!rst && rdy && !rollback && dsp_valid && dsp_ready) begin
         if (sb.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL pop_unexpected: dsp_pc=%0h, no entry expected", dsp_pc);
         end else begin
            mon_e = sb.pop_front();
            chk("dsp_pc", dsp_pc, mon_e.pc);
            chk("dsp_instr", dsp_instr, mon_e.instr);
            chk("dsp_jump", {31'd0, dsp_jump}, {31'd0, mon_e.jump});
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1);
   end

   initial begin
      rst = 1'b1; rdy = 1'b1; rollback = 1'b0; rollback_pc = '0;
      ic_resp_valid = 1'b0; ic_resp_instr = '0; pred_jump = 1'b0;
      pred_next_pc = '0; dsp_ready = 1'b0;
      tick(); tick();
      st("reset", 1'b0, 32'h0, 0);
      chk("reset.pred_pc", pred_pc, 32'h0);
      rst = 1'b0;

      //           resp ipc    jmp npc    drdy reqv reqpc  cnt
      tbl[0]  = mkv(0, 32'h00, 0, 32'h00, 1,   1, 32'h00, 0);
      tbl[1]  = mkv(1, 32'h00, 0, 32'h04, 1,   1, 32'h04, 1);
      tbl[2]  = mkv(1, 32'h04, 0, 32'h08, 1,   1, 32'h08, 1);
      tbl[3]  = mkv(1, 32'h08, 0, 32'h0C, 1,   1, 32'h0C, 1);
      tbl[4]  = mkv(1, 32'h0C, 1, 32'h40, 1,   1, 32'h40, 1);
      tbl[5]  = mkv(1, 32'h40, 0, 32'h44, 0,   1, 32'h44, 2);
      tbl[6]  = mkv(1, 32'h44, 0, 32'h48, 0,   1, 32'h48, 3);
      tbl[7]  = mkv(1, 32'h48, 0, 32'h4C, 0,   0, 32'h48, 4);
      tbl[8]  = mkv(0, 32'h00, 0, 32'h00, 0,   0, 32'h48, 4);
      tbl[9]  = mkv(0, 32'h00, 0, 32'h00, 1,   0, 32'h48, 3);
      tbl[10] = mkv(0, 32'h00, 0, 32'h00, 0,   1, 32'h4C, 3);
      tbl[11] = mkv(1, 32'h4C, 0, 32'h50, 1,   1, 32'h50, 3);
      tbl[12] = mkv(1, 32'h50, 0, 32'h20, 1,   1, 32'h20, 3);
      tbl[13] = mkv(0, 32'h00, 0, 32'h00, 1,   1, 32'h20, 2);
      tbl[14] = mkv(0, 32'h00, 0, 32'h00, 1,   1, 32'h20, 1);
      tbl[15] = mkv(0, 32'h00, 0, 32'h00, 0,   1, 32'h20, 1);

      for (int i = 0; i < 16; i++) begin
         step(1'b0, 32'h0, tbl[i].resp, tbl[i].ipc, tbl[i].resp, tbl[i].jump,
              tbl[i].npc, tbl[i].drdy);
         st($sformatf("vec%0d", i), tbl[i].e_reqv, tbl[i].e_reqpc, tbl[i].e_cnt);
      end

      // Rollback during a 3-cycle miss: address held, response dropped.
      step(1'b1, 32'h100, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
      st("rb_miss0", 1'b1, 32'h20, 0);
      chk("rb_miss0.pred_pc", pred_pc, 32'h100);
      step(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1);
      st("rb_miss1", 1'b1, 32'h20, 0);
      step(1'b0, 32'h0, 1'b1, 32'h20, 1'b0, 1'b0, 32'h999, 1'b1);
      st("rb_miss_resp", 1'b0, 32'h20, 0);
      chk("rb_miss_resp.pred_pc", pred_pc, 32'h100);
      step(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
      st("rb_reissue", 1'b1, 32'h100, 0);

      // Rollback coinciding with a response and a dispatch pop.
      step(1'b0, 32'h0, 1'b1, 32'h100, 1'b1, 1'b0, 32'h104, 1'b0);
      st("rb_co_fill", 1'b1, 32'h104, 1);
      step(1'b1, 32'h200, 1'b1, 32'h104, 1'b0, 1'b0, 32'h999, 1'b1);
      st("rb_co", 1'b0, 32'h104, 0);
      chk("rb_co.pred_pc", pred_pc, 32'h200);
      step(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
      st("rb_co_reissue", 1'b1, 32'h200, 0);

      // rdy low freezes everything despite a response and dsp_ready.
      step(1'b0, 32'h0, 1'b1, 32'h200, 1'b1, 1'b0, 32'h204, 1'b0);
      st("frz_fill", 1'b1, 32'h204, 1);
      rdy = 1'b0;
      for (int k = 0; k < 3; k++) begin
         ic_resp_valid = 1'b1;
         ic_resp_instr = mk_instr(32'h204);
         pred_next_pc  = 32'h999;
         dsp_ready     = 1'b1;
         #1;
         chk($sformatf("frz%0d.pred_valid", k), {31'd0, pred_valid}, 32'd1);
         chk($sformatf("frz%0d.pred_instr", k), pred_instr, mk_instr(32'h204));
         tick();
         st($sformatf("frz%0d", k), 1'b1, 32'h204, 1);
         chk($sformatf("frz%0d.dsp_pc", k), dsp_pc, 32'h200);
         chk($sformatf("frz%0d.pred_pc", k), pred_pc, 32'h204);
      end
      ic_resp_valid = 1'b0;
      rdy = 1'b1;
      step(1'b0, 32'h0, 1'b1, 32'h204, 1'b1, 1'b0, 32'h208, 1'b0);
      st("frz_resume", 1'b1, 32'h208, 2);
      step(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1);
      st("drain1", 1'b1, 32'h208, 1);
      step(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1);
      st("drain2", 1'b1, 32'h208, 0);
      dsp_ready = 1'b0;
      tick();
      chk("sb_empty", sb.size(), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
